// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: state/command encodings and trace entry width for the debug controller
package mips_dbg_pkg;
   typedef enum logic [1:0] {ST_CPU_RST = 2'b00, ST_HALT = 2'b01, ST_RUN = 2'b10, ST_STEP = 2'b11} state_e;
   typedef enum logic [1:0] {OP_RUN = 2'b00, OP_STEP = 2'b01, OP_HALT = 2'b10, OP_RESET_CPU = 2'b11} op_e;
   function automatic int trace_w(input int pc_w, input int reg_aw, input int data_w);
      return pc_w + reg_aw + data_w;
   endfunction
endpackage

// File: rtl/mips_debug_ctrl_if.sv
// mips_debug_ctrl_if: command, core and trace signals between bench/board and the debug controller
interface mips_debug_ctrl_if
   import mips_dbg_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 6,
   parameter int REG_AW      = 3,
   parameter int TRACE_DEPTH = 16
);
   localparam int TW = trace_w(PC_W, REG_AW, DATA_W);
   localparam int CW = $clog2(TRACE_DEPTH + 1);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [15:0]       cmd_count;
   logic              bp_en;
   logic [PC_W-1:0]   bp_pc;
   logic [PC_W-1:0]   pc;
   logic              reg_write;
   logic [REG_AW-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic              cpu_rst;
   logic              cpu_ce;
   logic              trace_rd;
   logic [TW-1:0]     trace_data;
   logic              trace_valid;
   logic [CW-1:0]     trace_count;
   logic              trace_overflow;
   logic [1:0]        state;
   logic              halted;
   logic              bp_hit;
   logic [31:0]       cycle_count;
   modport master (
      output cmd_valid, cmd_op, cmd_count, bp_en, bp_pc, pc, reg_write, write_reg, write_data, trace_rd,
      input  cmd_ready, cpu_rst, cpu_ce, trace_data, trace_valid, trace_count, trace_overflow,
             state, halted, bp_hit, cycle_count
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_count, bp_en, bp_pc, pc, reg_write, write_reg, write_data, trace_rd,
      output cmd_ready, cpu_rst, cpu_ce, trace_data, trace_valid, trace_count, trace_overflow,
             state, halted, bp_hit, cycle_count
   );
endinterface

// File: rtl/dbg_trace_fifo.sv
// dbg_trace_fifo: show-ahead FIFO with synchronous clear and sticky overflow on dropped pushes
module dbg_trace_fifo #(
   parameter  int W     = 17,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o,
   output logic          overflow_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          ovf_q, full, do_push, do_pop;
   assign empty_o    = cnt_q == '0;
   assign full       = cnt_q == CW'(DEPTH);
   assign do_pop     = pop_i && !empty_o;
   // a pop frees the slot, so a full FIFO can still accept a simultaneous push
   assign do_push    = push_i && (!full || do_pop);
   assign dout_o     = mem_q[rd_q];
   assign count_o    = cnt_q;
   assign overflow_o = ovf_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
         ovf_q <= ovf_q || (push_i && !do_push);
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: run control (reset/run/halt/step), PC breakpoint, cycle counter and write-back trace
module mips_debug_ctrl
   import mips_dbg_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 6,
   parameter int REG_AW      = 3,
   parameter int TRACE_DEPTH = 16,
   parameter int RST_CYCLES  = 2
) (
   input logic              clk,
   input logic              rst,
   mips_debug_ctrl_if.slave dbg
);
   localparam int TW = trace_w(PC_W, REG_AW, DATA_W);
   localparam int RW = $clog2(RST_CYCLES + 1);
   state_e        state_q, state_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic [15:0]   rem_q, rem_d;
   logic          bp_skip_q, bp_skip_d, bp_hit_q, bp_hit_d;
   logic [31:0]   cyc_q;
   logic          active, accept, rst_cmd, bp_fire, ce, empty;
   always_comb begin
      active  = state_q == ST_RUN || state_q == ST_STEP;
      accept  = dbg.cmd_valid && state_q != ST_CPU_RST;
      rst_cmd = accept && dbg.cmd_op == OP_RESET_CPU;
      bp_fire = active && dbg.bp_en && dbg.pc == dbg.bp_pc && !bp_skip_q;
      ce      = active && !bp_fire && !rst_cmd;
   end
   // priority: RESET_CPU > breakpoint > HALT command > step completion
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      rem_d     = rem_q;
      bp_skip_d = bp_skip_q;
      bp_hit_d  = bp_hit_q;
      if (ce) begin
         bp_skip_d = 1'b0;
         rem_d     = rem_q - 16'd1;
      end
      if (state_q == ST_CPU_RST) begin
         rst_cnt_d = rst_cnt_q - RW'(1);
         state_d   = rst_cnt_q == RW'(1) ? ST_HALT : ST_CPU_RST;
      end else if (rst_cmd) begin
         state_d   = ST_CPU_RST;
         rst_cnt_d = RW'(RST_CYCLES);
         bp_hit_d  = 1'b0;
      end else if (state_q == ST_HALT) begin
         if (accept && (dbg.cmd_op == OP_RUN || dbg.cmd_op == OP_STEP)) begin
            state_d   = dbg.cmd_op == OP_RUN ? ST_RUN : ST_STEP;
            rem_d     = dbg.cmd_count == '0 ? 16'd1 : dbg.cmd_count;
            bp_skip_d = 1'b1;
            bp_hit_d  = 1'b0;
         end
      end else if (bp_fire) begin
         state_d  = ST_HALT;
         bp_hit_d = 1'b1;
      end else if ((accept && dbg.cmd_op == OP_HALT) || (state_q == ST_STEP && rem_q == 16'd1)) begin
         state_d = ST_HALT;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q   <= ST_CPU_RST;
         rst_cnt_q <= RW'(RST_CYCLES);
         rem_q     <= '0;
         bp_skip_q <= 1'b0;
         bp_hit_q  <= 1'b0;
         cyc_q     <= '0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         rem_q     <= rem_d;
         bp_skip_q <= bp_skip_d;
         bp_hit_q  <= bp_hit_d;
         cyc_q     <= rst_cmd ? '0 : cyc_q + 32'(ce);
      end
   dbg_trace_fifo #(.W(TW), .DEPTH(TRACE_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (rst_cmd),
      .push_i    (ce && dbg.reg_write),
      .pop_i     (dbg.trace_rd),
      .din_i     ({dbg.pc, dbg.write_reg, dbg.write_data}),
      .dout_o    (dbg.trace_data),
      .empty_o   (empty),
      .count_o   (dbg.trace_count),
      .overflow_o(dbg.trace_overflow)
   );
   assign dbg.cmd_ready   = state_q != ST_CPU_RST;
   assign dbg.cpu_rst     = state_q == ST_CPU_RST;
   assign dbg.cpu_ce      = ce;
   assign dbg.state       = state_q;
   assign dbg.halted      = state_q == ST_HALT;
   assign dbg.bp_hit      = bp_hit_q;
   assign dbg.cycle_count = cyc_q;
   assign dbg.trace_valid = !empty;
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: directed run-control/trace scenarios checked against a queue-based behavioural model
module tb_mips_debug_ctrl;
   localparam int DATA_W = 8, PC_W = 6, REG_AW = 3, DEPTH = 16, RST_CYCLES = 2;
   logic clk = 1'b0;
   logic rst;
   int   total = 0, bad = 0;
   bit   wr_en = 1'b0;
   mips_debug_ctrl_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .TRACE_DEPTH(DEPTH)) dbg_if ();
   mips_debug_ctrl #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .TRACE_DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES))
      dut (.clk(clk), .rst(rst), .dbg(dbg_if));
   always #5 clk = ~clk;
   // simple core: PC advances by one per enabled cycle, write-back pattern derived from the PC
   always @(posedge clk)
      if (dbg_if.cpu_rst) dbg_if.pc <= '0;
      else if (dbg_if.cpu_ce) dbg_if.pc <= dbg_if.pc + 6'd1;
   assign dbg_if.reg_write  = wr_en;
   assign dbg_if.write_reg  = dbg_if.pc[2:0];
   assign dbg_if.write_data = 8'(dbg_if.pc * 7 + 3);
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic logic [16:0] ent(input int p);
      logic [5:0] pp;
      pp = 6'(p);
      return {pp, pp[2:0], 8'(p * 7 + 3)};
   endfunction
   // behavioural model: mode 0 CPU_RST, 1 HALT, 2 RUN, 3 STEP
   int          m_mode, m_rcnt, m_rem;
   bit          m_skip, m_hit, m_ovf;
   logic [31:0] m_cyc;
   logic [16:0] q[$];
   bit          e_ce, e_fire, e_acc;
   function automatic bit m_ce();
      return m_mode >= 2 && !(dbg_if.bp_en && dbg_if.pc == dbg_if.bp_pc && !m_skip)
             && !(dbg_if.cmd_valid && dbg_if.cmd_op == 2'd3);
   endfunction
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_rcnt = RST_CYCLES; m_rem = 0; m_skip = 0; m_hit = 0; m_ovf = 0; m_cyc = 0;
         q.delete();
      end else begin
         e_ce   = m_ce();
         e_fire = m_mode >= 2 && dbg_if.bp_en && dbg_if.pc == dbg_if.bp_pc && !m_skip;
         e_acc  = dbg_if.cmd_valid && m_mode != 0;
         if (dbg_if.trace_rd && q.size() > 0) void'(q.pop_front());
         if (e_ce && dbg_if.reg_write) begin
            if (q.size() < DEPTH) q.push_back({dbg_if.pc, dbg_if.write_reg, dbg_if.write_data});
            else m_ovf = 1;
         end
         if (e_ce) begin m_cyc = m_cyc + 1; m_skip = 0; end
         if (m_mode == 0) begin
            m_rcnt--;
            if (m_rcnt == 0) m_mode = 1;
         end else if (e_acc && dbg_if.cmd_op == 2'd3) begin
            m_mode = 0; m_rcnt = RST_CYCLES; m_cyc = 0; m_ovf = 0; m_hit = 0;
            q.delete();
         end else if (m_mode == 1) begin
            if (e_acc && dbg_if.cmd_op < 2'd2) begin
               m_mode = dbg_if.cmd_op == 2'd0 ? 2 : 3;
               m_rem  = dbg_if.cmd_count == 0 ? 1 : int'(dbg_if.cmd_count);
               m_skip = 1; m_hit = 0;
            end
         end else if (e_fire) begin
            m_mode = 1; m_hit = 1;
         end else if (e_acc && dbg_if.cmd_op == 2'd2) begin
            m_mode = 1;
         end else if (m_mode == 3) begin
            m_rem--;
            if (m_rem == 0) m_mode = 1;
         end
      end
   end
   always @(negedge clk) begin
      chk("cpu_ce", dbg_if.cpu_ce, m_ce());
      chk("cmd_ready", dbg_if.cmd_ready, m_mode != 0);
      chk("cpu_rst", dbg_if.cpu_rst, m_mode == 0);
      chk("state", dbg_if.state, m_mode);
      chk("halted", dbg_if.halted, m_mode == 1);
      chk("bp_hit", dbg_if.bp_hit, m_hit);
      chk("cycle_count", dbg_if.cycle_count, m_cyc);
      chk("trace_count", dbg_if.trace_count, q.size());
      chk("trace_valid", dbg_if.trace_valid, q.size() != 0);
      chk("trace_overflow", dbg_if.trace_overflow, m_ovf);
      if (q.size() != 0) chk("trace_data", dbg_if.trace_data, q[0]);
   end
   task automatic cmd(input logic [1:0] op, input logic [15:0] n);
      dbg_if.cmd_valid = 1'b1;
      dbg_if.cmd_op    = op;
      dbg_if.cmd_count = n;
      @(posedge clk); #1;
      dbg_if.cmd_valid = 1'b0;
   endtask
   task automatic wait_halt(input int budget);
      int i = 0;
      while (!dbg_if.halted && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      chk("halt_reached", dbg_if.halted, 1'b1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      dbg_if.cmd_valid = 0; dbg_if.cmd_op = 0; dbg_if.cmd_count = 0;
      dbg_if.bp_en = 0; dbg_if.bp_pc = 0; dbg_if.trace_rd = 0;
      #3;
      chk("rst_state", dbg_if.state, 2'd0);
      chk("rst_cpu_rst", dbg_if.cpu_rst, 1'b1);
      chk("rst_ready", dbg_if.cmd_ready, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_hold1", dbg_if.cpu_rst, 1'b1);
      @(posedge clk); #1;
      chk("rst_release", dbg_if.cpu_rst, 1'b0);
      chk("idle_halted", dbg_if.state, 2'd1);
      chk("idle_ce", dbg_if.cpu_ce, 1'b0);
      chk("idle_cycles", dbg_if.cycle_count, 32'd0);
      // STEP 3, then STEP 0 executes one instruction
      cmd(2'd1, 16'd3);
      wait_halt(20);
      chk("step3_cycles", dbg_if.cycle_count, 32'd3);
      chk("step3_pc", dbg_if.pc, 6'd3);
      cmd(2'd1, 16'd0);
      wait_halt(20);
      chk("step0_cycles", dbg_if.cycle_count, 32'd4);
      // breakpoint at 4 from a fresh core
      cmd(2'd3, 16'd0);
      wait_halt(20);
      dbg_if.bp_en = 1; dbg_if.bp_pc = 6'd4;
      cmd(2'd0, 16'd0);
      wait_halt(40);
      chk("bp_pc", dbg_if.pc, 6'd4);
      chk("bp_ce", dbg_if.cpu_ce, 1'b0);
      chk("bp_hit", dbg_if.bp_hit, 1'b1);
      chk("bp_cycles", dbg_if.cycle_count, 32'd4);
      cmd(2'd1, 16'd1);
      wait_halt(20);
      chk("bp_resume_pc", dbg_if.pc, 6'd5);
      chk("bp_resume_hit", dbg_if.bp_hit, 1'b0);
      chk("bp_resume_cycles", dbg_if.cycle_count, 32'd5);
      dbg_if.bp_en = 0;
      // 20 write-backs into a 16-entry trace
      cmd(2'd3, 16'd0);
      wait_halt(20);
      wr_en = 1;
      cmd(2'd1, 16'd20);
      wait_halt(60);
      chk("ovf_count", dbg_if.trace_count, 5'd16);
      chk("ovf_flag", dbg_if.trace_overflow, 1'b1);
      wr_en = 0;
      for (int i = 0; i < DEPTH; i++) begin
         chk("pop_data", dbg_if.trace_data, ent(i));
         dbg_if.trace_rd = 1; @(posedge clk); #1;
         dbg_if.trace_rd = 0;
      end
      chk("drained_valid", dbg_if.trace_valid, 1'b0);
      chk("drained_ovf_sticky", dbg_if.trace_overflow, 1'b1);
      // full FIFO with simultaneous push and pop
      cmd(2'd3, 16'd0);
      wait_halt(20);
      wr_en = 1;
      cmd(2'd1, 16'd16);
      wait_halt(60);
      chk("full_count", dbg_if.trace_count, 5'd16);
      chk("full_ovf", dbg_if.trace_overflow, 1'b0);
      dbg_if.cmd_valid = 1; dbg_if.cmd_op = 2'd1; dbg_if.cmd_count = 16'd1;
      @(posedge clk); #1;
      dbg_if.cmd_valid = 0;
      dbg_if.trace_rd = 1;
      @(posedge clk); #1;
      dbg_if.trace_rd = 0;
      wait_halt(10);
      chk("pp_count", dbg_if.trace_count, 5'd16);
      chk("pp_ovf", dbg_if.trace_overflow, 1'b0);
      chk("pp_head", dbg_if.trace_data, ent(1));
      // RESET_CPU mid-RUN
      cmd(2'd0, 16'd0);
      repeat (3) begin @(posedge clk); #1; end
      chk("run_ovf", dbg_if.trace_overflow, 1'b1);
      dbg_if.cmd_valid = 1; dbg_if.cmd_op = 2'd3;
      #1 chk("rstcmd_ce", dbg_if.cpu_ce, 1'b0);
      @(posedge clk); #1;
      dbg_if.cmd_valid = 0;
      chk("rstcmd_state", dbg_if.state, 2'd0);
      chk("rstcmd_fifo", dbg_if.trace_count, 5'd0);
      chk("rstcmd_ovf", dbg_if.trace_overflow, 1'b0);
      chk("rstcmd_cycles", dbg_if.cycle_count, 32'd0);
      @(posedge clk); #1;
      chk("rstcmd_hold", dbg_if.cpu_rst, 1'b1);
      @(posedge clk); #1;
      chk("rstcmd_done", dbg_if.state, 2'd1);
      // asynchronous rst mid-STEP
      cmd(2'd1, 16'd10);
      repeat (2) begin @(posedge clk); #1; end
      chk("pre_rst_ce", dbg_if.cpu_ce, 1'b1);
      rst = 1'b1;
      #1;
      chk("arst_state", dbg_if.state, 2'd0);
      chk("arst_cpu_rst", dbg_if.cpu_rst, 1'b1);
      chk("arst_ce", dbg_if.cpu_ce, 1'b0);
      chk("arst_cycles", dbg_if.cycle_count, 32'd0);
      chk("arst_count", dbg_if.trace_count, 5'd0);
      chk("arst_valid", dbg_if.trace_valid, 1'b0);
      chk("arst_ready", dbg_if.cmd_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_halt(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
